// File: rtl/reverse_lut_scan.sv
// Reverse lookup table: searches the stored entries for a data value and returns
// the key/index of the lowest-indexed valid match, scanning one entry per cycle.
module reverse_lut_scan #(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1,
    parameter int IDX_LEN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [KEY_LEN-1:0]  rsp_key,
    output logic [IDX_LEN-1:0]  rsp_idx
);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NR_KEY - 1);

    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [KEY_LEN-1:0]  key_d  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] data_d [NR_KEY];

    state_t              state_q, state_d;
    logic [IDX_LEN-1:0]  scan_idx_q, scan_idx_d;
    logic [DATA_LEN-1:0] req_data_q, req_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [KEY_LEN-1:0]  rsp_key_q, rsp_key_d;
    logic [IDX_LEN-1:0]  rsp_idx_q, rsp_idx_d;

    logic                sel_valid;
    logic [KEY_LEN-1:0]  sel_key;
    logic [DATA_LEN-1:0] sel_data;
    logic                match;

    // Table update; out-of-range indices match no entry, and clr wins over a write.
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        data_d  = data_q;
        for (int i = 0; i < NR_KEY; i++) begin
            if (wr_en && wr_idx == IDX_LEN'(i)) begin
                valid_d[i] = 1'b1;
                key_d[i]   = wr_key;
                data_d[i]  = wr_data;
            end
        end
        if (clr) begin
            valid_d = '0;
        end
    end

    // Compare against registered contents so a same-cycle write is not seen.
    always_comb begin
        sel_valid = 1'b0;
        sel_key   = '0;
        sel_data  = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (scan_idx_q == IDX_LEN'(i)) begin
                sel_valid = valid_q[i];
                sel_key   = key_q[i];
                sel_data  = data_q[i];
            end
        end
        match = sel_valid && (sel_data == req_data_q);
    end

    // Handshakes: a transfer occurs on a rising edge where valid && ready are both 1;
    // rsp_* stay stable while rsp_valid is high and rsp_ready is low.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        req_data_d = req_data_q;
        rsp_hit_d  = rsp_hit_q;
        rsp_key_d  = rsp_key_q;
        rsp_idx_d  = rsp_idx_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_data_d = req_data;
                    scan_idx_d = '0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    rsp_hit_d = 1'b1;
                    rsp_key_d = sel_key;
                    rsp_idx_d = scan_idx_q;
                    state_d   = RESP;
                end else if (scan_idx_q == LAST_IDX) begin
                    rsp_hit_d = 1'b0;
                    rsp_key_d = '0;
                    rsp_idx_d = '0;
                    state_d   = RESP;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_LEN'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            state_q    <= IDLE;
            scan_idx_q <= '0;
            req_data_q <= '0;
            rsp_hit_q  <= 1'b0;
            rsp_key_q  <= '0;
            rsp_idx_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            req_data_q <= req_data_d;
            rsp_hit_q  <= rsp_hit_d;
            rsp_key_q  <= rsp_key_d;
            rsp_idx_q  <= rsp_idx_d;
        end
    end

    // Key/data need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_hit   = rsp_hit_q;
    assign rsp_key   = rsp_key_q;
    assign rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_reverse_lut_scan.sv
// Directed bench for reverse_lut_scan with 4 entries, 3-bit keys and 8-bit data.
module tb_reverse_lut_scan;

  logic       clk = 1'b0;
  logic       rst, wr_en, clr, req_valid, rsp_ready;
  logic [1:0] wr_idx;
  logic [2:0] wr_key;
  logic [7:0] wr_data, req_data;
  logic       req_ready, rsp_valid, rsp_hit;
  logic [2:0] rsp_key;
  logic [1:0] rsp_idx;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 0;

  reverse_lut_scan #(
    .NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8), .IDX_LEN(2)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
    .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit), .rsp_key(rsp_key), .rsp_idx(rsp_idx)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    lat++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [2:0] key, input logic [7:0] data);
    wr_en = 1'b1; wr_idx = idx; wr_key = key; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  // Presents a request in cycle T and returns in cycle T+1 with lat = 1.
  task automatic start_req(input string tag, input logic [7:0] data);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = data;
    tick();
    req_valid = 1'b0;
    lat = 1;
  endtask

  task automatic finish_rsp(input string tag, input int exp_lat, input logic exp_hit,
                            input logic [2:0] exp_key, input logic [1:0] exp_idx,
                            input int hold);
    while (!rsp_valid && lat < 30) tick();
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_hit"}, 32'(rsp_hit), 32'(exp_hit));
    chk({tag, "_key"}, 32'(rsp_key), 32'(exp_key));
    chk({tag, "_idx"}, 32'(rsp_idx), 32'(exp_idx));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_hold_hit"}, 32'(rsp_hit), 32'(exp_hit));
      chk({tag, "_hold_key"}, 32'(rsp_key), 32'(exp_key));
      chk({tag, "_hold_idx"}, 32'(rsp_idx), 32'(exp_idx));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    wr_idx = '0; wr_key = '0; wr_data = '0; req_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_key", 32'(rsp_key), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);

    // Empty table: full scan, miss at T+5.
    start_req("empty_miss", 8'h00);
    finish_rsp("empty_miss", 5, 1'b0, 3'd0, 2'd0, 0);

    // Single entry at idx2: hit at T+4.
    wr(2'd2, 3'd5, 8'hA7);
    start_req("hit_idx2", 8'hA7);
    finish_rsp("hit_idx2", 4, 1'b1, 3'd5, 2'd2, 0);

    // Duplicate data at idx1 and idx3: lowest index wins at T+3.
    wr(2'd1, 3'd1, 8'h3C);
    wr(2'd3, 3'd6, 8'h3C);
    start_req("dup_lowest", 8'h3C);
    finish_rsp("dup_lowest", 3, 1'b1, 3'd1, 2'd1, 0);

    // Backpressure: response held for 5 cycles with rsp_ready low.
    start_req("backpressure", 8'hA7);
    finish_rsp("backpressure", 4, 1'b1, 3'd5, 2'd2, 5);

    // clr together with a write: the write is discarded, everything invalid.
    clr = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_key = 3'd7; wr_data = 8'h11;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    start_req("clr_wins", 8'h11);
    finish_rsp("clr_wins", 5, 1'b0, 3'd0, 2'd0, 0);
    start_req("clr_all", 8'h3C);
    finish_rsp("clr_all", 5, 1'b0, 3'd0, 2'd0, 0);

    // Write during a scan: entry 3 is compared later, so the new entry is found.
    start_req("wr_mid_scan", 8'h99);
    wr(2'd3, 3'd4, 8'h99);
    finish_rsp("wr_mid_scan", 5, 1'b1, 3'd4, 2'd3, 0);

    // Write to the entry being compared in that same cycle is not seen.
    start_req("wr_same_cycle", 8'h42);
    wr(2'd0, 3'd2, 8'h42);
    finish_rsp("wr_same_cycle", 5, 1'b0, 3'd0, 2'd0, 0);

    // Reset in the middle of a scan that would otherwise hit.
    wr(2'd2, 3'd5, 8'hA7);
    start_req("rst_scan", 8'hA7);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_scan_req_ready", 32'(req_ready), 32'd1);
    chk("rst_scan_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("rst_scan_no_rsp", 32'(rsp_valid), 32'd0);
    start_req("rst_scan_inval2", 8'hA7);
    finish_rsp("rst_scan_inval2", 5, 1'b0, 3'd0, 2'd0, 0);
    start_req("rst_scan_inval3", 8'h99);
    finish_rsp("rst_scan_inval3", 5, 1'b0, 3'd0, 2'd0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
